// File: rtl/ctrl_regs_arbiter.sv
// ctrl_regs_arbiter: round-robin sharing of one AXI-Lite control-register port.
// Optional macro CTRL_ARB_TIMEOUT_EN adds a response timeout with a DRAIN state.
module ctrl_regs_arbiter #(
    parameter int NumReq        = 2,
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 1024
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumReq-1:0]             req_i,
    input  logic [NumReq-1:0]             we_i,
    input  logic [NumReq*AddrWidth-1:0]   addr_i,
    input  logic [NumReq*DataWidth-1:0]   wdata_i,
    input  logic [NumReq*DataWidth/8-1:0] strb_i,
    output logic [NumReq-1:0]             gnt_o,
    output logic [NumReq-1:0]             rsp_valid_o,
    output logic [DataWidth-1:0]          rsp_rdata_o,
    output logic                          rsp_err_o,
    output logic                          busy_o,
    output logic [AddrWidth-1:0]          aw_addr_o,
    output logic                          aw_valid_o,
    input  logic                          aw_ready_i,
    output logic [DataWidth-1:0]          w_data_o,
    output logic [DataWidth/8-1:0]        w_strb_o,
    output logic                          w_valid_o,
    input  logic                          w_ready_i,
    input  logic [1:0]                    b_resp_i,
    input  logic                          b_valid_i,
    output logic                          b_ready_o,
    output logic [AddrWidth-1:0]          ar_addr_o,
    output logic                          ar_valid_o,
    input  logic                          ar_ready_i,
    input  logic [DataWidth-1:0]          r_data_i,
    input  logic [1:0]                    r_resp_i,
    input  logic                          r_valid_i,
    output logic                          r_ready_o
);

    localparam int IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int StrbW = DataWidth / 8;

    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WR_REQ = 3'd1;
    localparam logic [2:0] WR_RSP = 3'd2;
    localparam logic [2:0] RD_REQ = 3'd3;
    localparam logic [2:0] RD_RSP = 3'd4;
`ifdef CTRL_ARB_TIMEOUT_EN
    localparam logic [2:0] DRAIN  = 3'd5;
`endif

    logic [2:0]           state_q, state_d;
    logic [IdxW-1:0]      ptr_q;
    logic [IdxW-1:0]      idx_q;
    logic                 we_q;
    logic [AddrWidth-1:0] addr_q;
    logic [DataWidth-1:0] wdata_q;
    logic [StrbW-1:0]     strb_q;
    logic                 aw_done_q, w_done_q;

    logic [2*NumReq-1:0]  req_dbl, req_rot;
    logic                 win_found;
    logic [IdxW-1:0]      win_idx;
    logic                 grant;
    logic                 aw_hs, w_hs;
    logic                 wr_fin, rd_fin;
    logic                 tmo;

    assign req_dbl = {req_i, req_i};
    assign req_rot = req_dbl >> ptr_q;

    // winner: first request at or after the pointer, wrapping around
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (!win_found && req_rot[i]) begin
                win_found = 1'b1;
                win_idx   = IdxW'((int'(ptr_q) + i) % NumReq);
            end
        end
    end

    assign grant = (state_q == IDLE) && win_found;

    // one-hot grant, only while idle
    always_comb begin
        gnt_o = '0;
        if (grant) gnt_o[win_idx] = 1'b1;
    end

    assign aw_valid_o = (state_q == WR_REQ) && !aw_done_q;
    assign w_valid_o  = (state_q == WR_REQ) && !w_done_q;
    assign ar_valid_o = (state_q == RD_REQ);
    assign aw_addr_o  = addr_q;
    assign ar_addr_o  = addr_q;
    assign w_data_o   = wdata_q;
    assign w_strb_o   = strb_q;
    assign busy_o     = (state_q != IDLE);

`ifdef CTRL_ARB_TIMEOUT_EN
    assign b_ready_o = (state_q == WR_RSP) || ((state_q == DRAIN) && we_q);
    assign r_ready_o = (state_q == RD_RSP) || ((state_q == DRAIN) && !we_q);
`else
    assign b_ready_o = (state_q == WR_RSP);
    assign r_ready_o = (state_q == RD_RSP);
`endif

    assign aw_hs  = aw_valid_o && aw_ready_i;
    assign w_hs   = w_valid_o && w_ready_i;
    assign wr_fin = (state_q == WR_RSP) && b_valid_i;
    assign rd_fin = (state_q == RD_RSP) && r_valid_i;

`ifdef CTRL_ARB_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);

    logic [CntW-1:0] cnt_q;
    logic            waiting;

    assign waiting = (state_q == WR_RSP) || (state_q == RD_RSP);
    assign tmo     = waiting && (cnt_q == CntW'(TimeoutCycles - 1));

    // cycles spent waiting for B/R; zero on every entry into a wait state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (!waiting) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end
`else
    // the timeout parameter is inert without the counter
    assign tmo = (TimeoutCycles < 0);
`endif

    // next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) state_d = we_i[win_idx] ? WR_REQ : RD_REQ;
            end
            WR_REQ: begin
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WR_RSP;
            end
            WR_RSP: begin
                if (b_valid_i) state_d = IDLE;
`ifdef CTRL_ARB_TIMEOUT_EN
                else if (tmo) state_d = DRAIN;
`endif
            end
            RD_REQ: begin
                if (ar_ready_i) state_d = RD_RSP;
            end
            RD_RSP: begin
                if (r_valid_i) state_d = IDLE;
`ifdef CTRL_ARB_TIMEOUT_EN
                else if (tmo) state_d = DRAIN;
`endif
            end
`ifdef CTRL_ARB_TIMEOUT_EN
            DRAIN: begin
                if (we_q ? b_valid_i : r_valid_i) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // state, pointer and latched request
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                ptr_q   <= (win_idx == LastIdx) ? '0 : win_idx + IdxW'(1);
                idx_q   <= win_idx;
                we_q    <= we_i[win_idx];
                addr_q  <= addr_i[win_idx*AddrWidth +: AddrWidth];
                wdata_q <= wdata_i[win_idx*DataWidth +: DataWidth];
                strb_q  <= strb_i[win_idx*StrbW +: StrbW];
            end
        end
    end

    // AW/W completion flags, live only inside WR_REQ
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (state_q != WR_REQ) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
        end
    end

    // registered completion pulse routed to the owning requester
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_o <= '0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            rsp_valid_o <= '0;
            if (wr_fin) begin
                rsp_valid_o[idx_q] <= 1'b1;
                rsp_err_o          <= (b_resp_i != 2'b00);
            end else if (rd_fin) begin
                rsp_valid_o[idx_q] <= 1'b1;
                rsp_rdata_o        <= r_data_i;
                rsp_err_o          <= (r_resp_i != 2'b00);
            end else if (tmo) begin
                rsp_valid_o[idx_q] <= 1'b1;
                rsp_err_o          <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ctrl_regs_arbiter.sv
// tb_ctrl_regs_arbiter: directed stimulus with queue-based response scoreboard.
// A small AXI-Lite slave model answers; addr 0x10 is read-only (SLVERR on write).
module tb_ctrl_regs_arbiter;

    typedef struct {
        int          idx;
        bit          err;
        logic [31:0] rdata;
    } rsp_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } axi_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [1:0]  req_i = '0;
    logic [1:0]  we_i = '0;
    logic [63:0] addr_i = '0;
    logic [63:0] wdata_i = '0;
    logic [7:0]  strb_i = '0;
    logic [1:0]  gnt_o, rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o, busy_o;
    logic [31:0] aw_addr_o, ar_addr_o, w_data_o, r_data_i;
    logic [3:0]  w_strb_o;
    logic        aw_valid_o, aw_ready_i, w_valid_o, w_ready_i;
    logic [1:0]  b_resp_i, r_resp_i;
    logic        b_valid_i, b_ready_o, ar_valid_o, ar_ready_i;
    logic        r_valid_i, r_ready_o;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_gnt_cyc = 0;
    int last_rsp_cyc = 0;
    int last_aw_cyc = 0;
    int aw_hi = 0;
    int w_hi = 0;
    int aw_dly = 0;
    int aw_wait;
    bit b_hold = 0;
    logic [31:0] mdl_rd = '0;
    logic [31:0] wr_addr;
    logic aw_got, w_got;

    rsp_t exp_rsp[$];
    axi_t exp_axi[$];
    int   exp_gnt[$];

    ctrl_regs_arbiter #(
        .NumReq(2), .AddrWidth(32), .DataWidth(32), .TimeoutCycles(16)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .strb_i(strb_i),
        .gnt_o(gnt_o), .rsp_valid_o(rsp_valid_o),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o),
        .aw_addr_o(aw_addr_o), .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
        .w_data_o(w_data_o), .w_strb_o(w_strb_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
        .b_resp_i(b_resp_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
        .ar_addr_o(ar_addr_o), .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
        .r_data_i(r_data_i), .r_resp_i(r_resp_i),
        .r_valid_i(r_valid_i), .r_ready_o(r_ready_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // slave model
    assign aw_ready_i = (aw_wait >= aw_dly);
    assign w_ready_i  = 1'b1;
    assign ar_ready_i = 1'b1;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_wait   <= 0;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            wr_addr   <= '0;
            b_valid_i <= 1'b0;
            b_resp_i  <= 2'b00;
            r_valid_i <= 1'b0;
            r_data_i  <= '0;
            r_resp_i  <= 2'b00;
        end else begin
            if (aw_valid_o && !aw_ready_i) aw_wait <= aw_wait + 1;
            else if (aw_valid_o) aw_wait <= 0;
            if (aw_valid_o && aw_ready_i) begin
                aw_got  <= 1'b1;
                wr_addr <= aw_addr_o;
            end
            if (w_valid_o && w_ready_i) w_got <= 1'b1;
            if (b_valid_i && b_ready_o) begin
                b_valid_i <= 1'b0;
                aw_got    <= 1'b0;
                w_got     <= 1'b0;
            end else if (!b_valid_i && !b_hold &&
                         (aw_got || (aw_valid_o && aw_ready_i)) &&
                         (w_got || (w_valid_o && w_ready_i))) begin
                b_valid_i <= 1'b1;
                b_resp_i  <= ((aw_got ? wr_addr : aw_addr_o) == 32'h10) ?
                             2'b10 : 2'b00;
            end
            if (ar_valid_o && ar_ready_i) begin
                r_valid_i <= 1'b1;
                r_data_i  <= (ar_addr_o == 32'h8) ? 32'h8000_0000 :
                             (ar_addr_o ^ 32'hA5A5_0000);
                r_resp_i  <= (ar_addr_o == 32'hFC) ? 2'b11 : 2'b00;
            end else if (r_valid_i && r_ready_o) begin
                r_valid_i <= 1'b0;
            end
        end
    end

    // grant monitor
    always @(negedge clk_i) begin
        if (rst_ni && gnt_o != 2'b00) begin
            last_gnt_cyc = cyc;
            if (exp_gnt.size() == 0) begin
                chk("gnt_unexpected", gnt_o, 2'b00);
            end else begin
                chk("gnt", gnt_o, 64'(2'b01 << exp_gnt.pop_front()));
            end
        end
    end

    // response scoreboard
    always @(negedge clk_i) begin
        if (rst_ni && rsp_valid_o != 2'b00) begin
            rsp_t e;
            last_rsp_cyc = cyc;
            if (exp_rsp.size() == 0) begin
                chk("rsp_unexpected", rsp_valid_o, 2'b00);
            end else begin
                e = exp_rsp.pop_front();
                chk("rsp_valid", rsp_valid_o, 64'(2'b01 << e.idx));
                chk("rsp_err", rsp_err_o, e.err);
                chk("rsp_rdata", rsp_rdata_o, e.rdata);
            end
        end
    end

    // AXI-side monitor
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (aw_valid_o) aw_hi++;
            if (w_valid_o) w_hi++;
            if (aw_valid_o && aw_ready_i) begin
                last_aw_cyc = cyc;
                if (exp_axi.size() == 0) chk("aw_unexpected", 1, 0);
                else chk("aw_addr", aw_addr_o, exp_axi[0].addr);
            end
            if (w_valid_o && w_ready_i) begin
                if (exp_axi.size() == 0) chk("w_unexpected", 1, 0);
                else chk("w_data", {w_strb_o, w_data_o},
                         {exp_axi[0].strb, exp_axi[0].data});
            end
            if (b_valid_i && b_ready_o && exp_axi.size() != 0)
                void'(exp_axi.pop_front());
            if (ar_valid_o && ar_ready_i) begin
                if (exp_axi.size() == 0) begin
                    chk("ar_unexpected", 1, 0);
                end else begin
                    chk("ar_addr", ar_addr_o, exp_axi[0].addr);
                    void'(exp_axi.pop_front());
                end
            end
        end
    end

    task automatic req_op(input int r, input bit we, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb,
                          input bit err, input logic [31:0] rd);
        int   n;
        rsp_t e;
        axi_t a;
        req_i[r] = 1'b1;
        we_i[r] = we;
        addr_i[r*32 +: 32] = addr;
        wdata_i[r*32 +: 32] = data;
        strb_i[r*4 +: 4] = strb;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!gnt_o[r] && n < 60);
        if (!gnt_o[r]) begin
            total++;
            bad++;
            $display("FAIL gnt_wait r=%0d: got gnt=%b want bit %0d", r, gnt_o, r);
        end else begin
            if (!we) mdl_rd = rd;
            e.idx = r;
            e.err = err;
            e.rdata = mdl_rd;
            exp_rsp.push_back(e);
            a.we = we;
            a.addr = addr;
            a.data = data;
            a.strb = strb;
            exp_axi.push_back(a);
        end
        @(posedge clk_i);
        #1;
        req_i[r] = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_rsp.size() != 0 || busy_o) && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        chk({name, "_pending"}, exp_rsp.size(), 0);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_gnt", gnt_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rdata", rsp_rdata_o, 0);
        chk("rst_err", rsp_err_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_valids", {aw_valid_o, w_valid_o, ar_valid_o}, 0);
        chk("rst_readies", {b_ready_o, r_ready_o}, 0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // single write, latency gnt t0 / AW t1 / rsp t3
        exp_gnt.push_back(0);
        req_op(0, 1, 32'h0, 32'h1, 4'hF, 0, 0);
        wait_idle("t1");
        chk("t1_aw_lat", last_aw_cyc - last_gnt_cyc, 1);
        chk("t1_rsp_lat", last_rsp_cyc - last_gnt_cyc, 3);

        // read from requester 1 only
        exp_gnt.push_back(1);
        req_op(1, 0, 32'h8, 0, 0, 0, 32'h8000_0000);
        wait_idle("t2");

        // both held: grants alternate 0,1,0,1
        exp_gnt.push_back(0);
        exp_gnt.push_back(1);
        exp_gnt.push_back(0);
        exp_gnt.push_back(1);
        fork
            begin
                req_op(0, 1, 32'h20, 32'h1111_2222, 4'hF, 0, 0);
                req_op(0, 0, 32'h24, 0, 0, 0, 32'hA5A5_0024);
            end
            begin
                req_op(1, 1, 32'h30, 32'hDEAD_BEEF, 4'h3, 0, 0);
                req_op(1, 0, 32'h34, 0, 0, 0, 32'hA5A5_0034);
            end
        join
        wait_idle("t3");

        // AW ready delayed: aw_valid held 3 cycles, w_valid 1
        aw_dly = 2;
        aw_hi = 0;
        w_hi = 0;
        exp_gnt.push_back(0);
        req_op(0, 1, 32'h40, 32'h1234_5678, 4'hF, 0, 0);
        wait_idle("t4");
        chk("t4_aw_cycles", aw_hi, 3);
        chk("t4_w_cycles", w_hi, 1);
        aw_dly = 0;

        // write to read-only register: SLVERR
        exp_gnt.push_back(1);
        req_op(1, 1, 32'h10, 32'hFFFF_FFFF, 4'hF, 1, 0);
        wait_idle("t5");

        // read with error response
        exp_gnt.push_back(0);
        req_op(0, 0, 32'hFC, 0, 0, 1, 32'hA5A5_00FC);
        wait_idle("t6");

        // reset in the middle of a write
        aw_dly = 6;
        exp_gnt.push_back(0);
        req_op(0, 1, 32'h50, 32'h5555_AAAA, 4'hF, 0, 0);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_valids", {aw_valid_o, w_valid_o, ar_valid_o}, 0);
        exp_rsp.delete();
        exp_axi.delete();
        exp_gnt.delete();
        mdl_rd = '0;
        aw_dly = 0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // pointer back at 0 after reset
        exp_gnt.push_back(0);
        exp_gnt.push_back(1);
        fork
            req_op(0, 1, 32'h70, 32'h0000_0070, 4'h1, 0, 0);
            req_op(1, 1, 32'h74, 32'h0000_0074, 4'h2, 0, 0);
        join
        wait_idle("t8");

`ifdef CTRL_ARB_TIMEOUT_EN
        // B withheld: error response 16 cycles after WR_RSP entry
        b_hold = 1'b1;
        exp_gnt.push_back(0);
        req_op(0, 1, 32'h60, 32'h6666_6666, 4'hF, 1, 0);
        for (int n = 0; n < 40 && exp_rsp.size() != 0; n++) @(negedge clk_i);
        chk("tmo_pending", exp_rsp.size(), 0);
        chk("tmo_lat", last_rsp_cyc - last_gnt_cyc, 18);
        repeat (5) @(posedge clk_i);
        #1;
        chk("tmo_busy_drain", busy_o, 1);
        b_hold = 1'b0;
        wait_idle("tmo_drain");
        chk("tmo_busy_after", busy_o, 0);
        exp_gnt.push_back(1);
        req_op(1, 0, 32'h8, 0, 0, 0, 32'h8000_0000);
        wait_idle("tmo_after");
`endif

        repeat (3) @(posedge clk_i);
        chk("end_rsp_q", exp_rsp.size(), 0);
        chk("end_axi_q", exp_axi.size(), 0);
        chk("end_gnt_q", exp_gnt.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
